// File: rtl/mem_access_if.sv
// Byte-wide memory bus between the load/store sequencer and memory.
// The master issues one byte request at a time; the slave completes it with ack.
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access.sv
// Load/store sequencer: splits 1/2/4-byte accesses into little-endian byte transactions.
// Optional MEMACC_ALIGN_CHECK_EN turns misaligned half/word accesses into a fault pulse.
module mem_access (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_insize,
  input  logic        i_insign,
  input  logic [2:0]  i_outsize,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_rdata,
  mem_access_if.master bus
);

  // state | meaning
  // IDLE  | waiting for i_start
  // XFER  | byte transactions in flight, k selects the current byte
  // DONE  | completion (or fault) pulse cycle
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] asm_q;
  logic [2:0]  n_q;
  logic [1:0]  k;
  logic        store_q;
  logic        sign_q;

  logic        out_ok;
  logic        in_ok;
  logic [2:0]  n_dec;
  logic        misal;
  logic [1:0]  k_inc;
  logic        k_last;
  logic [31:0] asm_next;
  logic [31:0] ext;

  always_comb begin
    out_ok = (i_outsize == 3'd1) || (i_outsize == 3'd2) || (i_outsize == 3'd4);
    in_ok  = (i_insize == 3'd1) || (i_insize == 3'd2) || (i_insize == 3'd4);
    n_dec  = out_ok ? i_outsize : (in_ok ? i_insize : 3'd0);
    misal  = 1'b0;
`ifdef MEMACC_ALIGN_CHECK_EN
    misal  = ((n_dec == 3'd2) && i_addr[0]) || ((n_dec == 3'd4) && (i_addr[1:0] != 2'b00));
`endif
  end

  // Assembly including the byte arriving this cycle, so the final ack can publish directly.
  always_comb begin
    k_inc    = k + 2'd1;
    k_last   = ({1'b0, k} == (n_q - 3'd1));
    asm_next = asm_q;
    asm_next[{k, 3'b000} +: 8] = bus.rdata;
    case (n_q)
      3'd1:    ext = {{24{sign_q & asm_next[7]}}, asm_next[7:0]};
      3'd2:    ext = {{16{sign_q & asm_next[15]}}, asm_next[15:0]};
      default: ext = asm_next;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      asm_q     <= '0;
      n_q       <= '0;
      k         <= '0;
      store_q   <= 1'b0;
      sign_q    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_fault   <= 1'b0;
      o_rdata   <= '0;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
    end else begin
      o_done  <= 1'b0;
      o_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            n_q     <= n_dec;
            store_q <= out_ok;
            sign_q  <= i_insign;
            k       <= 2'd0;
            asm_q   <= '0;
            o_busy  <= 1'b1;
            if ((n_dec == 3'd0) || misal) begin
              state   <= DONE;
              o_done  <= ~misal;
              o_fault <= misal;
            end else begin
              state     <= XFER;
              bus.req   <= 1'b1;
              bus.we    <= out_ok;
              bus.addr  <= i_addr;
              bus.wdata <= i_wdata[7:0];
            end
          end
        end
        XFER: begin
          if (bus.ack) begin
            asm_q <= asm_next;
            if (k_last) begin
              state   <= DONE;
              bus.req <= 1'b0;
              bus.we  <= 1'b0;
              o_done  <= 1'b1;
              if (!store_q) o_rdata <= ext;
            end else begin
              k         <= k_inc;
              bus.addr  <= addr_q + {30'd0, k_inc};
              bus.wdata <= wdata_q[{k_inc, 3'b000} +: 8];
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
